// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the two-master RAM arbiter.
//   state_e : arbiter FSM states
//   AW_DEF  : default RAM word-address width
//   DW_DEF  : default RAM data width
package ram_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick.
//   req[1:0] : in  request vector, bit i = master i
//   last     : in  master granted most recently
//   winner   : out chosen master (0 when nobody requests)
// With both requesting, the master that was not granted last wins;
// a lone requester always wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  assign winner = (req[0] & req[1]) ? ~last : req[1];

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one external RAM between two masters.
//   clk, rst_n                    : clock, async active-low reset
//   mX_req/we/addr/wdata          : in  master X request (held until ack)
//   mX_ack/rdata                  : out one-cycle completion pulse, read result
//   w_en/w_addr/res               : out RAM write port
//   r_en/r_addr, r_data           : out/in RAM read port (r_data combinational)
//   busy                          : out transaction in flight (ACCESS/ACK)
//   gnt_id                        : out owner of current/last transaction
//
// state  | meaning
// IDLE   | no transaction; grant on any request
// ACCESS | single RAM cycle for the latched request
// ACK    | ack to winner; chain straight into the other master if waiting
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          w_en,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] res,
  output logic          r_en,
  output logic [AW-1:0] r_addr,
  input  logic [DW-1:0] r_data,
  output logic          busy,
  output logic          gnt_id
);

  state_e        state_q, state_d;
  logic          gnt_q, gnt_d;
  // last_q resets to 1 so the first contended grant goes to master 0,
  // while gnt_id itself still reads 0 out of reset.
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;

  logic [1:0]    pick_req;
  logic          pick_w;
  logic          load;
  logic [DW-1:0] result;

  // During ACK the master being acked may still hold req; mask it so only
  // the other master can chain in.
  always_comb begin
    pick_req = {m1_req, m0_req};
    if (state_q == ST_ACK) begin
      pick_req[gnt_q] = 1'b0;
    end
  end

  rr_pick2 u_pick (
    .req    (pick_req),
    .last   (last_q),
    .winner (pick_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    load    = 1'b0;
    result  = we_q ? '0 : r_data;

    case (state_q)
      ST_IDLE: begin
        if (|pick_req) begin
          load = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_ACK;
        if (gnt_q) begin
          rd1_d = result;
        end else begin
          rd0_d = result;
        end
      end
      ST_ACK: begin
        if (|pick_req) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_ACCESS;
      gnt_d   = pick_w;
      last_d  = pick_w;
      we_d    = pick_w ? m1_we    : m0_we;
      addr_d  = pick_w ? m1_addr  : m0_addr;
      wdata_d = pick_w ? m1_wdata : m0_wdata;
    end
  end

  // Enables decode straight from the state register, so an async reset
  // kills an in-flight access without waiting for a clock.
  assign w_en     = (state_q == ST_ACCESS) &  we_q;
  assign r_en     = (state_q == ST_ACCESS) & ~we_q;
  assign w_addr   = addr_q;
  assign r_addr   = addr_q;
  assign res      = wdata_q;
  assign busy     = (state_q != ST_IDLE);
  assign gnt_id   = gnt_q;
  assign m0_ack   = (state_q == ST_ACK) & ~gnt_q;
  assign m1_ack   = (state_q == ST_ACK) &  gnt_q;
  assign m0_rdata = rd0_q;
  assign m1_rdata = rd1_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 8, RAM address width.
REQ-002 Parameter DW, default 32, RAM data width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 m0_req / m1_req  in  1  access request from master 0 / 1, held until matching ack.
REQ-006 m0_we / m1_we  in  1  1 = write, 0 = read; stable while req high.
REQ-007 m0_addr / m1_addr  in  AW  word address; stable while req high.
REQ-008 m0_wdata / m1_wdata  in  DW  write data; stable while req high.
REQ-009 m0_ack / m1_ack  out  1  one-cycle completion pulse.
REQ-010 m0_rdata / m1_rdata  out  DW  read result, valid in the ack cycle; 0 for writes.
REQ-011 w_en  out  1  RAM write enable.
REQ-012 w_addr  out  AW  RAM write address.
REQ-013 res  out  DW  RAM write data.
REQ-014 r_en  out  1  RAM read enable.
REQ-015 r_addr  out  AW  RAM read address.
REQ-016 r_data  in  DW  RAM read data, combinational from r_en/r_addr.
REQ-017 busy  out  1  high in ACCESS and ACK states.
REQ-018 gnt_id  out  1  master owning the current/last transaction.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, ACK.
REQ-020 IDLE: if any req is high at a clock edge, the FSM SHALL go to ACCESS and latch the winner's id, we, addr, wdata.
REQ-021 Arbitration SHALL be round-robin: with both requesting, the master not granted last wins; a single requester always wins.
REQ-022 ACCESS (exactly one cycle): write → w_en=1, w_addr/res from latched fields, r_en=0; read → r_en=1, r_addr from latched addr, w_en=0.
REQ-023 At the end of ACCESS, r_data (read) or 0 (write) SHALL be registered into the winner's rdata register, then the FSM goes to ACK.
REQ-024 ACK: only the winner's ack SHALL be 1; the other ack SHALL be 0.
REQ-025 From ACK, if the other master's req is high, the FSM SHALL go directly to ACCESS for it; otherwise it SHALL go to IDLE.
REQ-026 The just-acked master's req SHALL be ignored during its ACK cycle; it SHALL drop req the cycle after ack.
REQ-027 Latency: req sampled high in IDLE at edge k → ACCESS in cycle k+1 → ack in cycle k+2.
REQ-028 Back-to-back, with both masters requesting continuously, there SHALL be one access per 2 cycles, alternating masters.
REQ-029 In IDLE and ACK, w_en and r_en SHALL be 0; RAM address/data outputs hold their latched values.
REQ-030 mX_rdata SHALL hold its value until that master's next ack.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, with w_en, r_en, acks, busy, gnt_id, rdata and latched fields all 0.
REQ-032 After reset the round-robin pointer SHALL favour master 0.
REQ-033 Reset during ACCESS SHALL abort the access combinationally (w_en drops with rst_n), and no ack SHALL be issued.

Structure
REQ-034 Package ram_arb_pkg SHALL hold the state enum and the AW/DW defaults.
REQ-035 The round-robin decision SHALL be a sub-module rr_pick2 (inputs req[1:0], last; output winner).
REQ-036 The RAM SHALL stay external, connected port-for-port to w_en/w_addr/res/r_en/r_addr/r_data.

Verification
REQ-037 Single read: preload addr 5 = 15; m0 reads addr 5 → m0_ack at edge+2, m0_rdata=15, m1_ack=0.
REQ-038 Write-then-read: m1 writes 0xDEADBEEF to addr 200, then reads addr 200 → m1_rdata=0xDEADBEEF; write ack carries rdata 0.
REQ-039 Contention: m0 and m1 both request in the same IDLE cycle after reset → m0 granted first, m1 in ACCESS the cycle after m0_ack; acks 2 cycles apart.
REQ-040 Fairness: both masters requesting continuously for 10 transactions → gnt_id alternates 0,1,0,1…; each master gets 5.
REQ-041 Reset mid-ACCESS of an m0 write of 7 to addr 3 → w_en=0 immediately, no ack, addr 3 unchanged, FSM in IDLE with outputs 0.
REQ-042 Read of addr 107 preloaded with -1 → rdata=0xFFFFFFFF; boundary addr 255 read/write round-trips correctly.
